tbus_rx_ctrl: RTL and testbench



---
 rtl/tbus_pkg.sv | 40 ++++
 rtl/tbus_fifo.sv | 59 +++++
 rtl/tbus_rx_ctrl.sv | 103 ++++++++++
 tb/tb_tbus_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tbus_pkg.sv
// Shared types and helpers for the tristate-bus receive controller.
// Latency: n/a (types and a combinational round-robin search).
// Backpressure: n/a.
package tbus_pkg;

   localparam int SRC_W = 3;
   localparam int MAX_N = 1 << SRC_W;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      SAMPLE,
      TURN
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SRC_W-1:0] idx;
   } pick_t;

   // Round-robin search starting at ptr+1, wrapping modulo n (n <= MAX_N).
   function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                     input logic [SRC_W-1:0] ptr,
                                     input int               n);
      pick_t            r;
      int               c;
      logic [SRC_W-1:0] ci;
      r = '0;
      for (int i = 1; i <= MAX_N; i++) begin
         c  = (int'(ptr) + i) % n;
         ci = SRC_W'(c);
         if ((i <= n) && !r.found && req[ci]) begin
            r.found = 1'b1;
            r.idx   = ci;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tbus_fifo.sv
// Small synchronous FIFO holding {source, data} words for the bus receiver.
// Latency: push visible at head one cycle later; head is a register read.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: CLK/RSTB clock and async active-low reset; i_push/i_push_dat write
// side; i_pop read side; o_dat head word; o_count/o_full/o_empty occupancy.
module tbus_fifo #(
   parameter int DW    = 11,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_push_dat,
   input  logic                       i_pop,
   output logic [DW-1:0]              o_dat,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_dat   = r_mem[r_rd];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Memory is reset so the head reads zero out of reset.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_push_dat;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/tbus_rx_ctrl.sv
// Round-robin grant of a shared tristate bus with break-before-make and FIFO capture.
// Latency: REQ in cycle t -> ENB in t+1,t+2 -> word pushed end of t+2 -> OUT_VALID t+3.
// Backpressure: no grant while FIFO holds DEPTH words; output is ready/valid.
// Ports: CLK/RSTB clock and async active-low reset; REQ/ENB per-driver request
// and tristate enable; BUS resolved bus value; OUT_* head word, source, handshake;
// FULL FIFO occupancy flag.
module tbus_rx_ctrl
   import tbus_pkg::*;
#(
   parameter int W     = 8,
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic [N-1:0]     REQ,
   output logic [N-1:0]     ENB,
   input  logic [W-1:0]     BUS,
   output logic [W-1:0]     OUT_DATA,
   output logic [SRC_W-1:0] OUT_SRC,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             FULL
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SRC_W-1:0] r_win;
   logic [SRC_W-1:0] w_win_nxt;
   logic [SRC_W-1:0] r_ptr;
   pick_t            w_pick;
   logic             w_elig;
   logic             w_grant;
   logic             w_push;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic [W+SRC_W-1:0] w_head;

   // Gate on the registered count only: a pop this cycle does not free a slot yet.
   assign w_pick = rr_pick(MAX_N'(REQ), r_ptr, N);
   assign w_elig = w_pick.found && (w_count < CW'(DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = r_win;
      case (r_state)
         IDLE, TURN: begin
            if (w_elig) begin
               w_state_nxt = GRANT;
               w_win_nxt   = w_pick.idx;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GRANT:   w_state_nxt = SAMPLE;
         SAMPLE:  w_state_nxt = TURN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         r_state <= IDLE;
         r_win   <= '0;
         r_ptr   <= SRC_W'(N - 1);
      end else begin
         r_state <= w_state_nxt;
         r_win   <= w_win_nxt;
         if (r_state == SAMPLE) r_ptr <= r_win;
      end
   end

   // Enables decode from registered state only, so reset drops them at once.
   assign w_grant = (r_state == GRANT) || (r_state == SAMPLE);
   always_comb begin
      ENB = '0;
      for (int i = 0; i < N; i++) ENB[i] = w_grant && (r_win == SRC_W'(i));
   end

   assign w_push = (r_state == SAMPLE);

   tbus_fifo #(
      .DW    (W + SRC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RSTB       (RSTB),
      .i_push     (w_push),
      .i_push_dat ({r_win, BUS}),
      .i_pop      (OUT_VALID && OUT_READY),
      .o_dat      (w_head),
      .o_count    (w_count),
      .o_full     (FULL),
      .o_empty    (w_empty)
   );

   assign OUT_VALID = !w_empty;
   assign OUT_SRC   = w_head[W+SRC_W-1:W];
   assign OUT_DATA  = w_head[W-1:0];

endmodule

// File: tb/tb_tbus_rx_ctrl.sv
// Directed bench for tbus_rx_ctrl: reset, single transfer, REQ drop,
// round-robin order, full gating, and simultaneous push/pop.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tbus_rx_ctrl;

   localparam int W     = 8;
   localparam int N     = 4;
   localparam int DEPTH = 4;

   logic         CLK = 1'b0;
   logic         RSTB = 1'b0;
   logic [N-1:0] REQ = '0;
   logic [N-1:0] ENB;
   logic [W-1:0] BUS;
   logic [W-1:0] OUT_DATA;
   logic [2:0]   OUT_SRC;
   logic         OUT_VALID;
   logic         OUT_READY = 1'b0;
   logic         FULL;

   logic [W-1:0] drv_dat [N];
   int           n_chk = 0;
   int           n_err = 0;

   always #5 CLK = ~CLK;

   // Resolved bus: whichever driver is enabled drives its word.
   always_comb begin
      BUS = '0;
      for (int i = 0; i < N; i++) if (ENB[i]) BUS = drv_dat[i];
   end

   tbus_rx_ctrl #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .REQ       (REQ),
      .ENB       (ENB),
      .BUS       (BUS),
      .OUT_DATA  (OUT_DATA),
      .OUT_SRC   (OUT_SRC),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .FULL      (FULL)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Advance until a grant appears (bounded), then compare the enable pattern.
   task automatic wait_grant(input string tag, input logic [N-1:0] exp);
      int k;
      k = 0;
      while ((ENB == '0) && (k < 12)) begin
         tick();
         k++;
      end
      chk(tag, 32'(ENB), 32'(exp));
   endtask

   task automatic do_reset();
      RSTB = 1'b0;
      tick();
      RSTB = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] oh;
      logic         extra;
      int           rr_exp [5];
      rr_exp = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) drv_dat[i] = '0;

      // Reset state
      tick();
      chk("rst_enb",   32'(ENB), 32'h0);
      chk("rst_valid", 32'(OUT_VALID), 32'h0);
      chk("rst_full",  32'(FULL), 32'h0);
      chk("rst_data",  32'(OUT_DATA), 32'h0);
      chk("rst_src",   32'(OUT_SRC), 32'h0);
      RSTB = 1'b1;
      tick();

      // Reset asserted during SAMPLE: enables drop immediately, no push
      drv_dat[1] = 8'h11;
      REQ = 4'b0010;
      wait_grant("mid_grant", 4'b0010);
      tick();
      chk("mid_sample", 32'(ENB), 32'h2);
      RSTB = 1'b0;
      #1;
      chk("mid_rst_enb",   32'(ENB), 32'h0);
      chk("mid_rst_valid", 32'(OUT_VALID), 32'h0);
      REQ = '0;
      tick();
      RSTB = 1'b1;
      tick();
      chk("mid_nopush", 32'(OUT_VALID), 32'h0);
      drv_dat[0] = 8'h5A;
      REQ = 4'b0001;
      tick();
      chk("post_rst_enb", 32'(ENB), 32'h1);
      tick();
      REQ = '0;
      tick();
      chk("post_rst_valid", 32'(OUT_VALID), 32'h1);
      chk("post_rst_data",  32'(OUT_DATA), 32'h5A);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("post_rst_pop", 32'(OUT_VALID), 32'h0);

      // Single transfer from driver 2
      drv_dat[2] = 8'hA5;
      REQ = 4'b0100;
      wait_grant("one_grant", 4'b0100);
      tick();
      chk("one_sample", 32'(ENB), 32'h4);
      REQ = '0;
      tick();
      chk("one_turn_enb", 32'(ENB), 32'h0);
      chk("one_valid",    32'(OUT_VALID), 32'h1);
      chk("one_data",     32'(OUT_DATA), 32'hA5);
      chk("one_src",      32'(OUT_SRC), 32'h2);
      tick();
      chk("one_idle_enb", 32'(ENB), 32'h0);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;

      // REQ[3] drops during GRANT: transfer still completes
      drv_dat[3] = 8'h77;
      REQ = 4'b1000;
      wait_grant("drop_grant", 4'b1000);
      REQ = '0;
      tick();
      chk("drop_sample", 32'(ENB), 32'h8);
      tick();
      chk("drop_valid", 32'(OUT_VALID), 32'h1);
      chk("drop_src",   32'(OUT_SRC), 32'h3);
      chk("drop_data",  32'(OUT_DATA), 32'h77);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;

      // Round-robin from reset pointer
      do_reset();
      for (int i = 0; i < N; i++) drv_dat[i] = 8'(8'h10 + i);
      REQ = 4'b1111;
      OUT_READY = 1'b1;
      for (int g = 0; g < 5; g++) begin
         oh = '0;
         oh[rr_exp[g]] = 1'b1;
         wait_grant($sformatf("rr%0d_grant", g), oh);
         tick();
         chk($sformatf("rr%0d_sample", g), 32'(ENB), 32'(oh));
         tick();
         chk($sformatf("rr%0d_turn", g), 32'(ENB), 32'h0);
         chk($sformatf("rr%0d_src", g),  32'(OUT_SRC), 32'(rr_exp[g]));
         chk($sformatf("rr%0d_data", g), 32'(OUT_DATA), 32'(8'h10 + rr_exp[g]));
         if (g == 4) REQ = '0;
      end
      tick();
      OUT_READY = 1'b0;

      // Full gating
      REQ = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         drv_dat[0] = 8'(k);
         wait_grant($sformatf("full%0d_grant", k), 4'b0001);
         tick();
         tick();
      end
      chk("full_flag",  32'(FULL), 32'h1);
      chk("full_valid", 32'(OUT_VALID), 32'h1);
      drv_dat[0] = 8'h05;
      extra = 1'b0;
      repeat (6) begin
         tick();
         if (ENB != '0) extra = 1'b1;
      end
      chk("full_no5th", 32'(extra), 32'h0);
      chk("full_head",  32'(OUT_DATA), 32'h1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("full_popcyc_enb", 32'(ENB), 32'h0);
      chk("full_after_pop",  32'(FULL), 32'h0);
      chk("full_head2",      32'(OUT_DATA), 32'h2);
      wait_grant("full5_grant", 4'b0001);
      tick();
      tick();
      REQ = '0;
      chk("full_again", 32'(FULL), 32'h1);
      OUT_READY = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("drain%0d_valid", k), 32'(OUT_VALID), 32'h1);
         chk($sformatf("drain%0d_data", k),  32'(OUT_DATA), 32'(k));
         tick();
      end
      OUT_READY = 1'b0;
      chk("drain_empty", 32'(OUT_VALID), 32'h0);

      // Simultaneous push and pop with two entries queued
      drv_dat[1] = 8'h31;
      REQ = 4'b0010;
      wait_grant("pp1_grant", 4'b0010);
      tick();
      tick();
      drv_dat[1] = 8'h32;
      wait_grant("pp2_grant", 4'b0010);
      tick();
      tick();
      drv_dat[1] = 8'h33;
      wait_grant("pp3_grant", 4'b0010);
      tick();
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      REQ = '0;
      chk("pp_valid", 32'(OUT_VALID), 32'h1);
      chk("pp_full",  32'(FULL), 32'h0);
      chk("pp_src",   32'(OUT_SRC), 32'h1);
      chk("pp_head",  32'(OUT_DATA), 32'h32);
      OUT_READY = 1'b1;
      tick();
      chk("pp_second", 32'(OUT_DATA), 32'h33);
      chk("pp_second_valid", 32'(OUT_VALID), 32'h1);
      tick();
      OUT_READY = 1'b0;
      chk("pp_empty", 32'(OUT_VALID), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
